// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU run-control slice: run state encoding,
// stop-cause codes and the CPU word width.
package cpu_pkg;

  localparam int CPU_WORD_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    STEP,
    DONE
  } run_state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_LIMIT = 2'b01;
  localparam logic [1:0] CAUSE_HALT  = 2'b10;
  localparam logic [1:0] CAUSE_BREAK = 2'b11;

endpackage

// File: rtl/cpu_cycle_counter.sv
// Cycle counter with synchronous clear and a sticky wrap flag.
// Clear has priority over enable.
module cpu_cycle_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         overflow
);

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      count_d = count_q + W'(1);
      if (&count_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer gating the CPU clock-enable (run/halt/resume/step, cycle limit).
// Optional breakpoint support is compiled in with CPU_RUN_CTRL_BREAK_EN.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W         = CPU_WORD_W,
  parameter int DEFAULT_LIMIT = 30
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Resume,
  input  logic             Step,
  input  logic             Halt,
  input  logic [CNT_W-1:0] CycleLimit,
`ifdef CPU_RUN_CTRL_BREAK_EN
  input  logic [CNT_W-1:0] Pc,
  input  logic [CNT_W-1:0] BreakAddr,
  input  logic             BreakOn,
`endif
  output logic             CpuEn,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Running,
  output logic             Done,
  output logic [1:0]       Cause,
  output logic             Overflow
);

  run_state_t       state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             start_go;
  logic             limit_hit;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = CycleCount + CNT_W'(1);
  // Evaluated only in RUN/STEP, where the current cycle is being counted.
  assign limit_hit = (limit_q != '0) && (count_inc == limit_q);

`ifdef CPU_RUN_CTRL_BREAK_EN
  logic skip_q, skip_d;
  logic brk_hit;
  // skip_q masks the match for the first enabled cycle after leaving a breakpoint.
  assign brk_hit = BreakOn && (Pc == BreakAddr) && !skip_q;
`endif

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    limit_d  = limit_q;
    start_go = 1'b0;
`ifdef CPU_RUN_CTRL_BREAK_EN
    skip_d   = cpu_en_q ? 1'b0 : skip_q;
`endif
    case (state_q)
      RUN: begin
        if (limit_hit) begin
          state_d = DONE;
          cause_d = CAUSE_LIMIT;
`ifdef CPU_RUN_CTRL_BREAK_EN
        end else if (brk_hit) begin
          state_d = PAUSE;
          cause_d = CAUSE_BREAK;
`endif
        end else if (Halt) begin
          state_d = PAUSE;
          cause_d = CAUSE_HALT;
        end
      end
      STEP: begin
        if (limit_hit) begin
          state_d = DONE;
          cause_d = CAUSE_LIMIT;
        end else begin
          state_d = PAUSE;
          cause_d = CAUSE_HALT;
        end
      end
      PAUSE: begin
        if (Start) begin
          start_go = 1'b1;
        end else if (Resume) begin
          state_d = RUN;
          cause_d = CAUSE_NONE;
`ifdef CPU_RUN_CTRL_BREAK_EN
          skip_d  = (cause_q == CAUSE_BREAK);
`endif
        end else if (Step) begin
          state_d = STEP;
        end
      end
      default: begin
        if (Start) start_go = 1'b1;
      end
    endcase

    if (start_go) begin
      state_d = RUN;
      cause_d = CAUSE_NONE;
      limit_d = CycleLimit;
`ifdef CPU_RUN_CTRL_BREAK_EN
      skip_d  = 1'b0;
`endif
    end

    cpu_en_d  = (state_d == RUN) || (state_d == STEP);
    running_d = cpu_en_d;
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      limit_q   <= CNT_W'(DEFAULT_LIMIT);
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      running_q <= running_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
      limit_q   <= limit_d;
    end
  end

`ifdef CPU_RUN_CTRL_BREAK_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end
`endif

  cpu_cycle_counter #(
    .W(CNT_W)
  ) u_cycle_counter (
    .clk      (Clock),
    .rst      (Reset),
    .clr      (start_go),
    .en       (cpu_en_q),
    .count    (CycleCount),
    .overflow (Overflow)
  );

  assign CpuEn   = cpu_en_q;
  assign Running = running_q;
  assign Done    = done_q;
  assign Cause   = cause_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run-control sequencer for the 24-bit CPU. It gates the CPU's clock-enable for a programmable number of cycles, with start, halt, resume and single-step control. It reports the cycles executed and the reason execution stopped. It sits between the top-level bench or debug logic and the CPU core, and it replaces the fixed free-running cycle loop.

Parameters:
CNT_W, 24, width of the cycle counter and cycle limit
DEFAULT_LIMIT, 30, cycle limit loaded at reset; 0 means unlimited

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  pulse: clear counter, latch limit, begin run
Resume  input  1  pulse: continue from PAUSE without clearing counter
Step  input  1  pulse: execute exactly one cycle from PAUSE
Halt  input  1  pulse: stop a run and enter PAUSE
CycleLimit  input  CNT_W  limit latched on Start; 0 means unlimited
CpuEn  output  1  registered clock-enable to the CPU core
CycleCount  output  CNT_W  number of CpuEn-high cycles since the last Start
Running  output  1  high in RUN or STEP
Done  output  1  high in DONE
Cause  output  2  stop cause: 00 none, 01 limit, 10 halt, 11 breakpoint
Overflow  output  1  sticky; set when CycleCount wraps

Behaviour:
- Clock is single; Reset is asynchronous and active-high.
- Reset values:
  - state IDLE
  - CpuEn=0, CycleCount=0, Running=0, Done=0, Cause=00, Overflow=0
  - latched limit = DEFAULT_LIMIT
- States: IDLE, RUN, PAUSE, STEP, DONE. All outputs are registered.
- Input priority in the same cycle: Halt > Start > Resume > Step.
- Start, from any state except RUN or STEP:
  - next cycle: RUN, CpuEn=1, CycleCount=0
  - limit latched from CycleLimit; Cause=00; Overflow cleared
- Start during RUN or STEP is ignored.
- Counting: every cycle with CpuEn=1, CycleCount increments by 1, modulo 2^CNT_W.
- On wrap from all-ones to 0, Overflow sets and stays set until the next Start or Reset.
- Limit termination:
  - In RUN or STEP, when the cycle being counted makes CycleCount+1 equal the limit, and the limit is nonzero, the next state is DONE with CpuEn=0 and Cause=01.
  - Net effect: CpuEn is high for exactly limit cycles.
  - A limit of 1 gives a single CpuEn cycle.
- Halt in RUN:
  - next cycle: PAUSE, CpuEn=0, Cause=10, CycleCount held
  - If Halt and the limit-reached condition occur in the same cycle, the limit wins: DONE with Cause=01.
- Halt in IDLE, PAUSE or DONE is ignored.
- Resume in PAUSE: next cycle RUN, CpuEn=1, counter not cleared, Cause=00. Ignored in all other states.
- Step in PAUSE:
  - next cycle: STEP with CpuEn=1 for exactly one cycle, then back to PAUSE with Cause=10
  - If that step reaches the limit, go to DONE with Cause=01 instead.
  - Step in any other state is ignored.
- Step with Start is not possible, because Start has priority.
- Unlimited run (limit 0) stops only on Halt, or on a breakpoint when that feature is compiled in.
- Reset mid-run: immediate asynchronous return to the reset values. CpuEn drops without waiting for a clock edge.

Optional Feature:
CPU_RUN_CTRL_BREAK_EN
- Compiled in, adds two ports:
  - Pc  input  CNT_W  current CPU program counter
  - BreakAddr  input  CNT_W  breakpoint address, with enable bit BreakOn  input  1
- In RUN, if BreakOn=1 and Pc==BreakAddr while CpuEn=1: next state PAUSE, CpuEn=0, Cause=11.
- Priority of the stop conditions: limit > breakpoint > Halt.
- Resume out of a breakpoint PAUSE ignores the breakpoint match for the first enabled cycle, so execution can leave the breakpoint address.
- Compiled out: the ports are absent and Cause=11 is never produced.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding typedef run_state_t (IDLE, RUN, PAUSE, STEP, DONE)
  - the cause constants CAUSE_NONE, CAUSE_LIMIT, CAUSE_HALT, CAUSE_BREAK
  - the CPU word width constant (24)
- One natural sub-module, cpu_cycle_counter: an enable/clear counter with wrap flag that provides CycleCount and Overflow.

Test Plan:
- Reset, then Start with CycleLimit=30 -> CpuEn high for exactly 30 cycles; CycleCount=30; Done=1; Cause=01.
- Start with limit 0; Halt after 10 cycles -> PAUSE; CycleCount=10; Cause=10. Then Step twice -> count 12, each Step giving exactly one CpuEn cycle. Then Resume -> RUN continues.
- Limit 5; Halt asserted on the cycle where the count reaches 5 -> DONE; Cause=01 (limit wins).
- CNT_W=4, limit 0, run 17 cycles -> CycleCount wraps to 1; Overflow=1. Next Start clears Overflow.
- Assert Reset asynchronously mid-run at count 7 -> CpuEn=0 and CycleCount=0 before the next clock edge. State IDLE and the limit reloads to 30.
- CPU_RUN_CTRL_BREAK_EN defined: BreakAddr=0x000010, Pc reaches 0x000010 -> PAUSE; Cause=11. Resume -> Pc advances past 0x000010 without an immediate re-break.
